program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter MEMORY_DEPTH, default 32, giving the number of program words the loader may write.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the word width; the value is fixed at 32 (4 bytes per word).
REQ-003 The block SHALL have port clk  input  1  system clock, rising-edge active.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port Start  input  1  level sampled each clk edge; begins a load when sampled high in IDLE, DONE or ERROR.
REQ-006 The block SHALL have port ByteIn  input  8  serial program byte.
REQ-007 The block SHALL have port ByteValid  input  1  ByteIn holds a valid byte.
REQ-008 The block SHALL have port ByteReady  output  1  loader can accept a byte this cycle.
REQ-009 The block SHALL have port MemWrite  output  1  one-cycle write strobe to program memory.
REQ-010 The block SHALL have port WriteAddress  output  DATA_WIDTH  byte address of the word being written.
REQ-011 The block SHALL have port WriteData  output  DATA_WIDTH  assembled instruction word.
REQ-012 The block SHALL have port Busy  output  1  load in progress; holds the CPU in reset.
REQ-013 The block SHALL have port Done  output  1  load completed successfully.
REQ-014 The block SHALL have port Error  output  1  load rejected because of a bad header.

Function
REQ-015 The block SHALL implement the states IDLE, HEADER, COLLECT, WRITE, DONE and ERROR, and all outputs SHALL be registered or decoded from state only.
REQ-016 A byte SHALL be accepted on a rising clk edge only when ByteValid=1 and ByteReady=1; ByteValid while ByteReady=0 SHALL be ignored and nothing SHALL be buffered.
REQ-017 ByteReady SHALL be 1 only in HEADER and COLLECT.
REQ-018 In IDLE, DONE and ERROR, Start=1 SHALL move the block to HEADER and clear the word index, byte count and Done/Error.
REQ-019 In HEADER, WRITE and COLLECT, Start SHALL be ignored.
REQ-020 In HEADER, the accepted byte SHALL be the word count N; if N=0 or N>MEMORY_DEPTH the block SHALL go to ERROR, otherwise it SHALL store N and go to COLLECT.
REQ-021 In COLLECT, each accepted byte SHALL shift in as word = {word[23:0], ByteIn}, so the first byte is the most significant; the 4th accepted byte SHALL move the block to WRITE.
REQ-022 WRITE SHALL last exactly one cycle with MemWrite=1, WriteData = the assembled word and WriteAddress = {index, 2'b00} zero-extended, giving byte addresses 0, 4, 8, and so on.
REQ-023 On leaving WRITE the index SHALL increment; if the incremented index equals N the block SHALL go to DONE, else to COLLECT.
REQ-024 Latency: when the 4th byte of a word is accepted at edge k, MemWrite SHALL be high for the cycle following edge k+1 only.
REQ-025 WriteAddress and WriteData SHALL hold their last values while MemWrite=0.
REQ-026 Busy SHALL be 1 in HEADER, COLLECT and WRITE and 0 otherwise.
REQ-027 Done SHALL be 1 only in DONE and Error SHALL be 1 only in ERROR; each SHALL persist until the next Start or reset.
REQ-028 The index SHALL be clog2(MEMORY_DEPTH)+1 bits wide so that N=MEMORY_DEPTH completes without wrap-around.

Reset
REQ-029 While reset=0, regardless of clk, the state SHALL be IDLE, the index, byte count and word register SHALL be 0, and all outputs (ByteReady, MemWrite, WriteAddress, WriteData, Busy, Done, Error) SHALL be 0.
REQ-030 A reset asserted mid-load SHALL abort the load immediately with no further MemWrite pulse; a partial word SHALL be discarded.
REQ-031 After reset deasserts, the block SHALL remain in IDLE until Start=1.

Verification
REQ-032 Normal load: Start, then bytes 02, 20,08,00,05, 01,09,50,20 -> MemWrite pulse at address 0x0 with data 0x20080005, pulse at 0x4 with 0x01095020, then Done=1, Busy=0.
REQ-033 Bad header: Start, header 00 -> Error=1, ByteReady=0, no MemWrite; a new Start with header 21 (33 > 32) -> Error=1 again.
REQ-034 Full depth: header 20 (32) with 128 bytes -> 32 pulses, last at address 0x7C, then Done=1.
REQ-035 Backpressure and gaps: random ByteValid gaps plus ByteValid held high during WRITE -> no byte lost or duplicated, and data matches the reference stream.
REQ-036 Mid-load reset: reset=0 after 6 data bytes -> all outputs 0 at once; a new Start reloads from address 0x0.
REQ-037 Start during COLLECT -> ignored; the load completes with correct data and addresses.

Source files
------------

// File: rtl/program_loader_if.sv
// Byte-stream and program-memory write bundle for program_loader.
// slave: loader side; master: byte source / memory / CPU-control side.
interface program_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  Start;
  logic [7:0]            ByteIn;
  logic                  ByteValid;
  logic                  ByteReady;
  logic                  MemWrite;
  logic [DATA_WIDTH-1:0] WriteAddress;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  Busy;
  logic                  Done;
  logic                  Error;

  modport slave (
    input  Start, ByteIn, ByteValid,
    output ByteReady, MemWrite,
    output WriteAddress, WriteData,
    output Busy, Done, Error
  );

  modport master (
    output Start, ByteIn, ByteValid,
    input  ByteReady, MemWrite,
    input  WriteAddress, WriteData,
    input  Busy, Done, Error
  );
endinterface

// File: rtl/program_loader.sv
// Serial program loader: header byte N, then N big-endian 32-bit words.
// Ports: clk, reset (async, active-low), bus (program_loader_if.slave).
module program_loader #(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32
) (
  input logic              clk,
  input logic              reset,
  program_loader_if.slave  bus
);
  localparam int IW = $clog2(MEMORY_DEPTH) + 1;
  localparam logic [8:0] MAXN = 9'(MEMORY_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    COLLECT,
    WRITE,
    DONE,
    ERROR
  } state_t;

  state_t                state;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         n;
  logic [1:0]            cnt;
  logic [31:0]           word;
  logic                  mw;
  logic [DATA_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [IW-1:0]         idx_nxt;
  logic                  take;
  logic                  ready;

  assign idx_nxt = idx + 1'b1;
  assign ready   = (state == HEADER) || (state == COLLECT);
  assign take    = ready && bus.ByteValid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
      n     <= '0;
      cnt   <= '0;
      word  <= '0;
      mw    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      mw <= 1'b0;
      unique case (state)
        IDLE, DONE, ERROR: begin
          if (bus.Start) begin
            state <= HEADER;
            idx   <= '0;
            cnt   <= '0;
            word  <= '0;
          end
        end
        HEADER: begin
          if (take) begin
            if (bus.ByteIn == 8'd0 ||
                {1'b0, bus.ByteIn} > MAXN) begin
              state <= ERROR;
            end else begin
              n     <= IW'(bus.ByteIn);
              state <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (take) begin
            word <= {word[23:0], bus.ByteIn};
            cnt  <= cnt + 2'd1;
            if (cnt == 2'd3) state <= WRITE;
          end
        end
        WRITE: begin
          // strobe and bus are registered, so the pulse
          // lands in the cycle after WRITE
          mw    <= 1'b1;
          waddr <= DATA_WIDTH'({idx, 2'b00});
          wdata <= DATA_WIDTH'(word);
          idx   <= idx_nxt;
          state <= (idx_nxt == n) ? DONE : COLLECT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ByteReady    = ready;
  assign bus.MemWrite     = mw;
  assign bus.WriteAddress = waddr;
  assign bus.WriteData    = wdata;
  assign bus.Busy  = (state == HEADER) || (state == COLLECT) ||
                     (state == WRITE);
  assign bus.Done  = (state == DONE);
  assign bus.Error = (state == ERROR);
endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader.
// Reference: byte stream -> expected (address, data, time) queues.
module tb_program_loader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   passed = 0;

  program_loader_if #(.DATA_WIDTH(32)) bus ();

  program_loader #(.MEMORY_DEPTH(32), .DATA_WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] obs_a[$];
  logic [31:0] obs_d[$];
  time         obs_t[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];
  time         exp_t[$];

  always @(negedge clk) begin
    if (bus.MemWrite === 1'b1) begin
      obs_a.push_back(bus.WriteAddress);
      obs_d.push_back(bus.WriteData);
      obs_t.push_back($time);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps,
                           output time acc_t, output bit ok);
    int t = 0;
    if (gaps && $urandom_range(0, 1) == 1) begin
      int g = int'($urandom_range(1, 3));
      for (int i = 0; i < g; i++) begin
        @(negedge clk);
        bus.ByteValid = 1'b0;
        bus.ByteIn = 8'($urandom);
      end
    end
    @(negedge clk);
    bus.ByteValid = 1'b1;
    bus.ByteIn = b;
    while (bus.ByteReady !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    ok = (t < 50);
    @(posedge clk);
    #1;
    acc_t = $time;
    checks++;
    if (!ok) $display("FAIL byte_accept: ByteReady never high, byte %h", b);
    else passed++;
  endtask

  task automatic do_load(input logic [7:0] b[$], input bit gaps,
                         input bit smid);
    time acc;
    bit ok;
    int n;
    int k;
    exp_a.delete(); exp_d.delete(); exp_t.delete();
    obs_a.delete(); obs_d.delete(); obs_t.delete();
    n = int'(b[0]);
    if (n >= 1 && n <= 32) begin
      for (int i = 0; i < n && 4 * i + 4 < b.size(); i++) begin
        exp_a.push_back(32'(4 * i));
        exp_d.push_back({b[4*i+1], b[4*i+2], b[4*i+3], b[4*i+4]});
      end
    end
    @(negedge clk);
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    for (int j = 0; j < b.size(); j++) begin
      if (smid && j == 1) bus.Start = 1'b1;
      if (smid && j == b.size() - 1) bus.Start = 1'b0;
      send_byte(b[j], gaps, acc, ok);
      if (!ok) break;
      // the 4th byte of a word is accepted at edge k; the strobe
      // is seen at the falling edge after edge k+1
      if (j >= 1 && j % 4 == 0) exp_t.push_back(acc - 1 + 15);
    end
    bus.Start = 1'b0;
    @(negedge clk);
    bus.ByteValid = 1'b0;
    k = 0;
    while (bus.Done !== 1'b1 && bus.Error !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.Start = 1'b0;
    bus.ByteValid = 1'b0;
    bus.ByteIn = 8'h00;
    #2;
    checks++;
    if ({bus.ByteReady, bus.MemWrite, bus.Busy, bus.Done, bus.Error}
        !== 5'b0 || bus.WriteAddress !== 32'h0 || bus.WriteData !== 32'h0)
      $display("FAIL reset_outputs: rdy/mw/busy/done/err=%b addr=%h data=%h want 0",
               {bus.ByteReady, bus.MemWrite, bus.Busy, bus.Done, bus.Error},
               bus.WriteAddress, bus.WriteData);
    else passed++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bus.ByteValid = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b0 || bus.ByteReady !== 1'b0)
      $display("FAIL idle_hold: busy=%b rdy=%b want 0 0",
               bus.Busy, bus.ByteReady);
    else passed++;
    bus.ByteValid = 1'b0;
  endtask

  task automatic test_normal;
    logic [7:0] b[$] = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                         8'h01, 8'h09, 8'h50, 8'h20};
    do_load(b, 1'b0, 1'b0);
    checks++;
    if (obs_a.size() != 2)
      $display("FAIL normal_count: got %0d want 2", obs_a.size());
    else passed++;
    for (int i = 0; i < obs_a.size() && i < 2; i++) begin
      checks++;
      if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i] ||
          obs_t[i] !== exp_t[i])
        $display("FAIL normal_word%0d: got %h/%h@%0t want %h/%h@%0t", i,
                 obs_a[i], obs_d[i], obs_t[i], exp_a[i], exp_d[i], exp_t[i]);
      else passed++;
    end
    checks++;
    if (bus.Done !== 1'b1 || bus.Busy !== 1'b0 || bus.Error !== 1'b0)
      $display("FAIL normal_status: done=%b busy=%b err=%b want 1 0 0",
               bus.Done, bus.Busy, bus.Error);
    else passed++;
  endtask

  task automatic test_bad_header;
    logic [7:0] b0[$] = '{8'h00};
    logic [7:0] b1[$] = '{8'h21};
    do_load(b0, 1'b0, 1'b0);
    checks++;
    if (bus.Error !== 1'b1 || bus.ByteReady !== 1'b0 ||
        bus.Done !== 1'b0 || obs_a.size() != 0)
      $display("FAIL hdr_zero: err=%b rdy=%b done=%b writes=%0d want 1 0 0 0",
               bus.Error, bus.ByteReady, bus.Done, obs_a.size());
    else passed++;
    do_load(b1, 1'b0, 1'b0);
    checks++;
    if (bus.Error !== 1'b1 || bus.Busy !== 1'b0 || obs_a.size() != 0)
      $display("FAIL hdr_33: err=%b busy=%b writes=%0d want 1 0 0",
               bus.Error, bus.Busy, obs_a.size());
    else passed++;
  endtask

  task automatic test_full_depth;
    logic [7:0] b[$];
    int bad = 0;
    b.push_back(8'h20);
    for (int i = 0; i < 128; i++) b.push_back(8'($urandom));
    do_load(b, 1'b0, 1'b0);
    checks++;
    if (obs_a.size() != 32)
      $display("FAIL full_count: got %0d want 32", obs_a.size());
    else passed++;
    for (int i = 0; i < obs_a.size() && i < 32; i++)
      if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i] ||
          obs_t[i] !== exp_t[i]) bad++;
    checks++;
    if (bad != 0) $display("FAIL full_words: %0d bad words want 0", bad);
    else passed++;
    checks++;
    if (obs_a.size() == 0 || obs_a[obs_a.size()-1] !== 32'h7C ||
        bus.Done !== 1'b1)
      $display("FAIL full_last: last addr=%h done=%b want 0000007c 1",
               obs_a.size() ? obs_a[obs_a.size()-1] : 32'hx, bus.Done);
    else passed++;
  endtask

  task automatic rand_load(input string name, input bit smid);
    logic [7:0] b[$];
    int n = int'($urandom_range(2, 8));
    int bad = 0;
    b.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) b.push_back(8'($urandom));
    do_load(b, 1'b1, smid);
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++)
      if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i]) bad++;
    checks++;
    if (obs_a.size() != n || bad != 0 || bus.Done !== 1'b1)
      $display("FAIL %s: writes=%0d bad=%0d done=%b want %0d 0 1",
               name, obs_a.size(), bad, bus.Done, n);
    else passed++;
  endtask

  task automatic test_back_to_back;
    for (int r = 0; r < 3; r++) rand_load("gaps_load", 1'b0);
  endtask

  task automatic test_start_in_collect;
    for (int r = 0; r < 2; r++) rand_load("start_collect", 1'b1);
  endtask

  task automatic test_mid_reset;
    logic [7:0] b[$] = '{8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h11, 8'h22};
    logic [7:0] b2[$] = '{8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    time acc;
    bit ok;
    obs_a.delete(); obs_d.delete(); obs_t.delete();
    @(negedge clk);
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    for (int j = 0; j < b.size(); j++) send_byte(b[j], 1'b0, acc, ok);
    reset = 1'b0;
    bus.ByteValid = 1'b0;
    #1;
    checks++;
    if ({bus.ByteReady, bus.MemWrite, bus.Busy, bus.Done, bus.Error}
        !== 5'b0 || bus.WriteAddress !== 32'h0 || bus.WriteData !== 32'h0)
      $display("FAIL midreset_outputs: flags=%b addr=%h data=%h want 0",
               {bus.ByteReady, bus.MemWrite, bus.Busy, bus.Done, bus.Error},
               bus.WriteAddress, bus.WriteData);
    else passed++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (obs_a.size() != 1 || bus.Busy !== 1'b0)
      $display("FAIL midreset_abort: writes=%0d busy=%b want 1 0",
               obs_a.size(), bus.Busy);
    else passed++;
    do_load(b2, 1'b0, 1'b0);
    checks++;
    if (obs_a.size() != 1 || obs_a[0] !== 32'h0 || obs_d[0] !== 32'hCAFEF00D)
      $display("FAIL midreset_reload: writes=%0d addr=%h data=%h want 1 0 cafef00d",
               obs_a.size(), obs_a.size() ? obs_a[0] : 32'hx,
               obs_d.size() ? obs_d[0] : 32'hx);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_bad_header();
    test_full_depth();
    test_back_to_back();
    test_start_in_collect();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
